// File: rtl/vl_pkg.sv
// rtl/vl_pkg.sv - shared state encodings and write-helper handshake constants for the store path
//   WORD_SHIFT     : log2 of bytes per result word
//   store_state_t  : store-controller FSM encodings (0x8..0xE, kept apart from the loader's codes)
//   TXN_ASSERT/TXN_DEASSERT : handshake strobe levels shared with mem_cntrl
package vl_pkg;

    localparam int WORD_SHIFT = 2;

    localparam logic TXN_ASSERT   = 1'b1;
    localparam logic TXN_DEASSERT = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'h8,
        ST_FETCH       = 4'h9,
        ST_CAPTURE     = 4'hA,
        ST_WRITE       = 4'hB,
        ST_RELEASE     = 4'hC,
        ST_DONE        = 4'hD,
        ST_WRITE_ERROR = 4'hE
    } store_state_t;

endpackage

// File: rtl/mem_store_cntrl_if.sv
// rtl/mem_store_cntrl_if.sv - result FIFO and AXI write-helper signals of the store controller
//   fifo_empty/fifo_rdata/fifo_re                 : result FIFO pop side
//   start_store/write_data/write_offset           : request to the write helper
//   txn_done/txn_error/cntrl_reset                : write-helper completion and release
//   master = store controller, slave = FIFO + write helper
interface mem_store_cntrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_re;
    logic                  start_store;
    logic [DATA_WIDTH-1:0] write_data;
    logic [ADDR_WIDTH-1:0] write_offset;
    logic                  txn_done;
    logic                  txn_error;
    logic                  cntrl_reset;

    modport master (
        input  fifo_empty, fifo_rdata, txn_done, txn_error,
        output fifo_re, start_store, write_data, write_offset, cntrl_reset
    );

    modport slave (
        output fifo_empty, fifo_rdata, txn_done, txn_error,
        input  fifo_re, start_store, write_data, write_offset, cntrl_reset
    );
endinterface

// File: rtl/mem_store_cntrl.sv
// rtl/mem_store_cntrl.sv - drains result words from the FIFO into single-word AXI write transactions
//   clk, reset (sync, active-high)
//   start, num_results, dest_base : run request, sampled in IDLE
//   bus (master)                   : FIFO pop + write-helper handshake
//   busy, store_count, store_done, error : run status
module mem_store_cntrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_SHIFT = vl_pkg::WORD_SHIFT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           num_results,
    input  logic [ADDR_WIDTH-1:0] dest_base,
    mem_store_cntrl_if.master     bus,
    output logic                  busy,
    output logic [15:0]           store_count,
    output logic                  store_done,
    output logic                  error
);
    import vl_pkg::*;

    store_state_t          state;
    store_state_t          state_n;
    logic [15:0]           count;
    logic [15:0]           num_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  fifo_re_c;
    logic                  start_store_c;
    logic                  cntrl_reset_c;
    logic [16:0]           count_inc;

    // 17-bit so that num_results = 0xFFFF terminates instead of wrapping
    assign count_inc = {1'b0, count} + 17'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            num_q  <= '0;
            base_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_q  <= num_results;
                        base_q <= dest_base;
                        count  <= '0;
                    end
                end
                ST_CAPTURE: data_q <= bus.fifo_rdata;
                ST_RELEASE: begin
                    if (!bus.txn_done) begin
                        count <= count_inc[15:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n       = state;
        fifo_re_c     = TXN_DEASSERT;
        start_store_c = TXN_DEASSERT;
        cntrl_reset_c = TXN_DEASSERT;
        unique case (state)
            ST_IDLE: begin
                cntrl_reset_c = TXN_ASSERT;
                if (start) begin
                    state_n = (num_results == 16'd0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!bus.fifo_empty) begin
                    fifo_re_c = TXN_ASSERT;
                    state_n   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_n = ST_WRITE;
            ST_WRITE: begin
                start_store_c = TXN_ASSERT;
                if (bus.txn_done) begin
                    state_n = bus.txn_error ? ST_WRITE_ERROR : ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // helper must drop txn_done before the next word may be fetched
                cntrl_reset_c = TXN_ASSERT;
                if (!bus.txn_done) begin
                    state_n = (count_inc == {1'b0, num_q}) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE, ST_WRITE_ERROR: begin
                state_n = state;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // the reset cycle must never pop a word
    assign bus.fifo_re      = fifo_re_c && !reset;
    assign bus.start_store  = start_store_c;
    assign bus.cntrl_reset  = cntrl_reset_c;
    assign bus.write_data   = data_q;
    assign bus.write_offset = base_q + (ADDR_WIDTH'(count) << WORD_SHIFT);

    assign busy        = !(state inside {ST_IDLE, ST_DONE, ST_WRITE_ERROR});
    assign store_count = count;
    assign store_done  = (state == ST_DONE);
    assign error       = (state == ST_WRITE_ERROR);

endmodule

// File: tb/tb_mem_store_cntrl.sv
// tb/tb_mem_store_cntrl.sv - randomized self-checking bench for mem_store_cntrl
module tb_mem_store_cntrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_results;
    logic [31:0] dest_base;
    logic        busy;
    logic [15:0] store_count;
    logic        store_done;
    logic        error;

    mem_store_cntrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_store_cntrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WORD_SHIFT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_results (num_results),
        .dest_base   (dest_base),
        .bus         (bus.master),
        .busy        (busy),
        .store_count (store_count),
        .store_done  (store_done),
        .error       (error)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model: src holds every word pushed this run, avail of them released
    logic [31:0] src [$];
    int          avail = 0;
    int          rd_idx = 0;

    assign bus.fifo_empty = (rd_idx >= avail);

    always @(posedge clk) begin
        if (reset) begin
            rd_idx         <= 0;
            bus.fifo_rdata <= '0;
        end else if (bus.fifo_re && (rd_idx < avail)) begin
            bus.fifo_rdata <= src[rd_idx];
            rd_idx         <= rd_idx + 1;
        end
    end

    // ---------------- write-helper model: completes after lat cycles, releases hold cycles after cntrl_reset
    int lat = 2;
    int hold = 0;
    int err_idx = -1;
    int h_wait = 0;
    int h_hold = 0;
    int h_txn = 0;

    always @(posedge clk) begin
        if (reset) begin
            bus.txn_done  <= 1'b0;
            bus.txn_error <= 1'b0;
            h_wait = 0;
            h_hold = 0;
            h_txn  = 0;
        end else if (!bus.txn_done) begin
            if (bus.start_store) begin
                if (h_wait >= lat - 1) begin
                    bus.txn_done  <= 1'b1;
                    bus.txn_error <= (h_txn == err_idx);
                    h_txn  = h_txn + 1;
                    h_wait = 0;
                end else begin
                    h_wait = h_wait + 1;
                end
            end else begin
                h_wait = 0;
            end
        end else if (bus.cntrl_reset) begin
            if (h_hold >= hold) begin
                bus.txn_done  <= 1'b0;
                bus.txn_error <= 1'b0;
                h_hold = 0;
            end else begin
                h_hold = h_hold + 1;
            end
        end
    end

    // ---------------- compare process: every write and pop checked against the word-level model
    logic [31:0] exp_base = '0;
    int          wr_k = 0;
    int          n_re = 0;
    logic        prev_ss = 1'b0;
    logic [31:0] held_d, held_o;
    logic [31:0] wr_off [0:15];
    logic [31:0] wr_dat [0:15];
    int          mc_total = 0;
    int          mc_pass = 0;

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        mc_total++;
        if (act === exp) mc_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            wr_k    = 0;
            n_re    = 0;
            prev_ss = 1'b0;
        end else begin
            if (bus.fifo_re) begin
                n_re++;
                mchk("re_while_empty", 32'(bus.fifo_empty), 32'd0);
                mchk("re_while_done_high", 32'(bus.txn_done), 32'd0);
            end
            if (bus.start_store && !prev_ss) begin
                mchk("write_offset", bus.write_offset, exp_base + 32'(wr_k) * 32'd4);
                mchk("write_data", bus.write_data, (wr_k < src.size()) ? src[wr_k] : 32'hxxxxxxxx);
                if (wr_k < 16) begin
                    wr_off[wr_k] = bus.write_offset;
                    wr_dat[wr_k] = bus.write_data;
                end
                held_d = bus.write_data;
                held_o = bus.write_offset;
                wr_k++;
            end else if (bus.start_store) begin
                mchk("write_data_stable", bus.write_data, held_d);
                mchk("write_offset_stable", bus.write_offset, held_o);
            end
            prev_ss = bus.start_store;
        end
    end

    // ---------------- directed + random sequences
    int it_total = 0;
    int it_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        it_total++;
        if (act === exp) it_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        src.delete();
        avail   = 0;
        lat     = 2;
        hold    = 0;
        err_idx = -1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        src.push_back(w);
        avail++;
    endtask

    task automatic wait_end(input int bound);
        int c;
        c = 0;
        while (!(store_done || error) && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("run_timeout", 32'(store_done || error), 32'd1);
    endtask

    // end-of-run expectations from the word-level rules
    task automatic run_check(input int n, input int e);
        int nw, nc;
        repeat (4) @(negedge clk);
        nw = (e >= 0 && e < n) ? e + 1 : n;
        nc = (e >= 0 && e < n) ? e : n;
        chk("store_count", 32'(store_count), 32'(nc));
        chk("store_done", 32'(store_done), 32'(nc == n));
        chk("error", 32'(error), 32'(nc != n));
        chk("busy_end", 32'(busy), 32'd0);
        chk("start_store_end", 32'(bus.start_store), 32'd0);
        chk("writes", 32'(wr_k), 32'(nw));
        chk("fifo_pops", 32'(n_re), 32'(nw));
    endtask

    initial begin
        int c, k, n, pushed;
        reset = 1'b1;
        start = 1'b0;
        num_results = '0;
        dest_base = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_cntrl_reset", 32'(bus.cntrl_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_store_count", 32'(store_count), 32'd0);
        chk("rst_store_done", 32'(store_done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_start_store", 32'(bus.start_store), 32'd0);
        chk("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
        chk("rst_write_offset", bus.write_offset, 32'd0);

        // four words at 0x100, helper latency 5
        do_reset();
        lat = 5;
        exp_base = 32'h100;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        num_results = 16'd4;
        dest_base = 32'h100;
        start = 1'b1;
        c = 0;
        while (!bus.start_store && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("first_write_latency", 32'(c), 32'd3);
        start = 1'b0;
        wait_end(300);
        chk("t1_off0", wr_off[0], 32'h100);
        chk("t1_off1", wr_off[1], 32'h104);
        chk("t1_off2", wr_off[2], 32'h108);
        chk("t1_off3", wr_off[3], 32'h10C);
        chk("t1_dat0", wr_dat[0], 32'hA0);
        chk("t1_dat3", wr_dat[3], 32'hA3);
        run_check(4, -1);
        chk("t1_store_count", 32'(store_count), 32'd4);

        // zero-length run
        do_reset();
        num_results = 16'd0;
        start = 1'b1;
        @(negedge clk);
        chk("zero_done_next", 32'(store_done), 32'd1);
        start = 1'b0;
        run_check(0, -1);

        // FIFO empty for 10 cycles, then one word
        do_reset();
        exp_base = 32'h200;
        num_results = 16'd1;
        dest_base = 32'h200;
        start = 1'b1;
        repeat (10) @(negedge clk);
        chk("stall_no_pop", 32'(n_re), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        push(32'h55);
        wait_end(100);
        chk("stall_dat", wr_dat[0], 32'h55);
        chk("stall_off", wr_off[0], 32'h200);
        run_check(1, -1);
        start = 1'b0;

        // error response on the second word
        do_reset();
        err_idx = 1;
        exp_base = 32'h40;
        for (int i = 0; i < 3; i++) push(32'hC0 + 32'(i));
        num_results = 16'd3;
        dest_base = 32'h40;
        start = 1'b1;
        wait_end(200);
        start = 1'b0;
        run_check(3, 1);
        chk("err_store_count", 32'(store_count), 32'd1);

        // helper holds txn_done for 6 extra cycles
        do_reset();
        hold = 6;
        exp_base = 32'h0;
        push(32'h11);
        push(32'h22);
        num_results = 16'd2;
        dest_base = 32'h0;
        start = 1'b1;
        c = 0;
        while (!(bus.txn_done && bus.cntrl_reset) && c < 50) begin
            @(negedge clk);
            c++;
        end
        k = 0;
        while (bus.txn_done && k < 50) begin
            chk("release_hold", {30'd0, bus.cntrl_reset, bus.fifo_re}, 32'd2);
            @(negedge clk);
            k++;
        end
        chk("release_len_ge6", 32'(k >= 6), 32'd1);
        chk("no_pop_at_fall", 32'(bus.fifo_re), 32'd0);
        @(negedge clk);
        chk("pop_after_fall", 32'(bus.fifo_re), 32'd1);
        wait_end(200);
        start = 1'b0;
        run_check(2, -1);

        // reset while writing word 2
        do_reset();
        lat = 8;
        for (int i = 0; i < 4; i++) push(32'hD0 + 32'(i));
        exp_base = 32'h300;
        num_results = 16'd4;
        dest_base = 32'h300;
        start = 1'b1;
        c = 0;
        while (wr_k < 2 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reach_word2", 32'(wr_k), 32'd2);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_start_store", 32'(bus.start_store), 32'd0);
        chk("mid_rst_store_count", 32'(store_count), 32'd0);
        chk("mid_rst_store_done", 32'(store_done), 32'd0);
        chk("mid_rst_cntrl_reset", 32'(bus.cntrl_reset), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // randomized runs: late pushes, wrapping bases, errors, mid-run input changes
        for (int r = 0; r < 12; r++) begin
            do_reset();
            n = $urandom_range(1, 6);
            lat = $urandom_range(1, 4);
            hold = $urandom_range(0, 3);
            err_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            exp_base = (r % 3 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            pushed = $urandom_range(0, n);
            for (int i = 0; i < pushed; i++) push($urandom);
            num_results = 16'(n);
            dest_base = exp_base;
            start = 1'b1;
            c = 0;
            while (!(store_done || error) && c < 3000) begin
                @(negedge clk);
                c++;
                if (c == 2) begin
                    start = $urandom_range(0, 1);
                    num_results = 16'($urandom);
                    dest_base = $urandom;
                end
                if (pushed < n && $urandom_range(0, 2) == 0) begin
                    push($urandom);
                    pushed++;
                end
            end
            chk("rand_timeout", 32'(store_done || error), 32'd1);
            run_check(n, err_idx);
        end

        $display("%0d/%0d checks passed", it_pass + mc_pass, it_total + mc_total);
        $finish;
    end

endmodule

// File: doc/mem_store_cntrl.md
Name: mem_store_cntrl

Overview:
- Write-back counterpart to the vector loader's memory controller.
- Drains result words (kNN distances/indices) from the result FIFO and issues single-word write transactions to the AXI-master write helper, one transaction per word.
- Uses the same level-held start / txn_done / cntrl_reset handshake as the load path.
- Sits between the compute pipes' result FIFO and the AXI master write channel.

Parameters:
- DATA_WIDTH, 32, width of result words and write_data.
- ADDR_WIDTH, 32, width of dest_base and write_offset.
- WORD_SHIFT, 2, log2 of bytes per word; shifts the word count into a byte offset.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level; begins a store run when sampled high in IDLE.
- num_results  input  16  number of words to store; sampled in IDLE on start.
- dest_base  input  ADDR_WIDTH  byte base offset; sampled in IDLE on start.
- fifo_empty  input  1  result FIFO empty flag.
- fifo_rdata  input  DATA_WIDTH  FIFO read data, valid one cycle after fifo_re.
- fifo_re  output  1  FIFO pop strobe, one cycle per word.
- start_store  output  1  level request to the write helper; held until txn_done.
- write_data  output  DATA_WIDTH  registered word being written.
- write_offset  output  ADDR_WIDTH  byte offset of the current write.
- txn_done  input  1  write helper: response received; stays high until cntrl_reset.
- txn_error  input  1  write helper: response not OKAY; valid with txn_done.
- cntrl_reset  output  1  resets/releases the write helper between transactions.
- busy  output  1  high in every state except IDLE, DONE and WRITE_ERROR.
- store_count  output  16  number of words successfully written.
- store_done  output  1  sticky completion flag.
- error  output  1  sticky write-error flag.

Behaviour:
- Reset values:
  - State IDLE.
  - count, num_q, base_q and data_q = 0.
  - All strobes 0, except cntrl_reset = 1 (IDLE drives it).
  - Reset mid-run abandons the run; words already popped are lost. No FIFO interaction in the reset cycle.
- write_offset = base_q + (count << WORD_SHIFT), truncated to ADDR_WIDTH (wraps modulo 2^ADDR_WIDTH). count is zero-extended.
- store_count = count.
- States:
  - IDLE: cntrl_reset = 1.
    - On start = 1: latch num_q <= num_results and base_q <= dest_base, clear count.
    - Go to DONE if num_results == 0, else FETCH.
  - FETCH: if !fifo_empty, fifo_re = 1 and go to CAPTURE; else stay. fifo_re is never asserted while fifo_empty = 1.
  - CAPTURE: data_q <= fifo_rdata; go to WRITE.
  - WRITE: start_store = 1.
    - On txn_done && txn_error: go to WRITE_ERROR.
    - On txn_done && !txn_error: go to RELEASE.
    - Otherwise hold. write_data and write_offset are stable throughout WRITE.
  - RELEASE: cntrl_reset = 1.
    - Stay while txn_done = 1.
    - When txn_done = 0: count <= count + 1, then go to DONE if count + 1 == num_q, else FETCH.
  - DONE: store_done = 1; stays until reset. start is ignored.
  - WRITE_ERROR: error = 1; stays until reset. count is not incremented for the failed word.
- Latency:
  - First start_store is asserted 3 cycles after start (IDLE→FETCH→CAPTURE→WRITE) when the FIFO is non-empty.
  - Per-word overhead is 3 cycles plus write-helper latency plus release time.
- Boundary conditions:
  - start dropping mid-run: ignored; the run completes.
  - Changes to num_results/dest_base mid-run: ignored.
  - FIFO empties mid-run: FETCH stalls indefinitely with no timeout.
  - txn_done asserted outside WRITE: ignored.
  - txn_done high on entry to WRITE (helper not released): treated as completion. The helper contract forbids this case.
  - num_results = 0xFFFF: 16-bit count compare must not overflow. Compare is done on a 17-bit sum.

Decomposition:
- Shared package vl_pkg holds:
  - state encodings (4-bit, values distinct from the loader's);
  - WORD_SHIFT;
  - a common txn handshake constants block shared with mem_cntrl.
- No sub-module; single FSM with a datapath register set. Optional reuse of a shared offset_calc function from the package.

Test Plan:
- num_results=4, dest_base=0x100, FIFO preloaded 0xA0..0xA3, helper asserts txn_done 5 cycles after start_store → offsets 0x100, 0x104, 0x108, 0x10C with matching data; 4 fifo_re pulses; store_done=1; store_count=4.
- num_results=0, start=1 → DONE the next cycle; no fifo_re and no start_store.
- FIFO empty for 10 cycles after start, then one word 0x55 pushed → fifo_re only after the push; single write of 0x55 at dest_base.
- Second word's response returns txn_error=1 → error=1, store_count=1, no further fifo_re, start_store=0.
- Helper holds txn_done high 6 cycles after completion → FSM stays in RELEASE with cntrl_reset=1; next fifo_re follows txn_done falling.
- reset asserted while in WRITE of word 2 → next cycle: state IDLE, start_store=0, store_count=0, store_done=0, cntrl_reset=1.
